// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM slot multiplexer.
package tdm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      GAP   = 2'd2
   } tdm_state_t;

   // Circular channel index: (cur + offset) modulo num_ch.
   function automatic int unsigned ch_sel(input int unsigned cur,
                                          input int unsigned offset,
                                          input int unsigned num_ch);
      return (cur + offset) % num_ch;
   endfunction

endpackage

// File: rtl/tdm_next_ch.sv
// Round-robin finder: next channel after cur, or the first valid one after cur
// (cur itself last) when mode_skip is set.
module tdm_next_ch
   import tdm_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = 2
) (
   input  logic [CH_W-1:0]   cur,
   input  logic [NUM_CH-1:0] valid,
   input  logic              mode_skip,
   output logic [CH_W-1:0]   nxt,
   output logic              found
);

   always_comb begin
      nxt   = CH_W'(ch_sel(32'(cur), 1, NUM_CH));
      found = !mode_skip;
      if (mode_skip) begin
         // Walk from the farthest offset down so the nearest valid channel wins.
         for (int unsigned k = NUM_CH; k > 0; k--) begin
            if (valid[CH_W'(ch_sel(32'(cur), k, NUM_CH))]) begin
               nxt   = CH_W'(ch_sel(32'(cur), k, NUM_CH));
               found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tdm_slot_mux.sv
// Time-division multiplexer: NUM_CH valid/ready channels share one registered
// output stream, each owning a SLOT_LEN-cycle dwell window in round-robin order.
module tdm_slot_mux
   import tdm_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned SLOT_LEN = 16,
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned CNT_W   = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     mode_skip,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          slot_ch,
   output logic                     slot_start
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_LEN - 1);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("tdm_slot_mux: NUM_CH must be >= 1");
   end
   if (SLOT_LEN < 1) begin : g_bad_slot_len
      $error("tdm_slot_mux: SLOT_LEN must be >= 1");
   end

   tdm_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CH_W-1:0]   slot_ch_d;
   logic              skip_q, skip_d;
   logic              slot_start_d;
   logic [CH_W-1:0]   find_cur, find_nxt;
   logic              find_ok;
   logic              grant;
   logic              xfer;
   logic [DATA_W-1:0] sel_data;

   // From IDLE the search starts at slot_ch itself, so a resume keeps its place.
   assign find_cur = (state_q == IDLE) ? CH_W'(ch_sel(32'(slot_ch), NUM_CH - 1, NUM_CH))
                                       : slot_ch;

   tdm_next_ch #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_next_ch (
      .cur       (find_cur),
      .valid     (in_valid),
      .mode_skip (mode_skip),
      .nxt       (find_nxt),
      .found     (find_ok)
   );

   // State register and slot bookkeeping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= CNT_MAX;
         slot_ch    <= '0;
         skip_q     <= 1'b0;
         slot_start <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         slot_ch    <= slot_ch_d;
         skip_q     <= skip_d;
         slot_start <= slot_start_d;
      end
   end

   // Next-state: mode_skip is latched only when a slot opens.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      slot_ch_d    = slot_ch;
      skip_d       = skip_q;
      slot_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = CNT_MAX;
            if (enable && find_ok) begin
               state_d      = DWELL;
               slot_ch_d    = find_nxt;
               skip_d       = mode_skip;
               slot_start_d = 1'b1;
            end
         end
         DWELL: begin
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q == '0) ||
                (skip_q && !in_valid[slot_ch] && (cnt_q != CNT_MAX))) begin
               state_d = GAP;
            end
         end
         GAP: begin
            cnt_d = CNT_MAX;
            if (find_ok) begin
               slot_ch_d = find_nxt;
            end
            if (enable && find_ok) begin
               state_d      = DWELL;
               skip_d       = mode_skip;
               slot_start_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Ready decode: only the slot owner, only while the output can take a word.
   always_comb begin
      grant    = (state_q == DWELL) && enable && (!out_valid || out_ready);
      in_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready[i] = grant && (slot_ch == CH_W'(i));
      end
      xfer     = grant && in_valid[slot_ch];
      sel_data = in_data[32'(slot_ch) * DATA_W +: DATA_W];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tdm_slot_mux.sv
// Directed bench for tdm_slot_mux: per-cycle vector table (4 ch, 4-cycle slots)
// plus hand sequences for async reset and a 1-channel/1-cycle-slot instance.
module tb_tdm_slot_mux;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable, mode_skip, out_ready;
   logic [3:0]  in_valid, in_ready;
   logic [7:0]  d0;
   logic [31:0] in_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [1:0]  slot_ch;
   logic        slot_start;

   logic       en1, vld1, ir1, ordy1, ov1, ch1, ss1;
   logic [7:0] dat1, od1;

   assign in_data = {8'hD3, 8'hC2, 8'hB1, d0};

   always #5 clock = ~clock;

   tdm_slot_mux #(.NUM_CH(4), .DATA_W(8), .SLOT_LEN(4)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .mode_skip(mode_skip),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .slot_ch(slot_ch), .slot_start(slot_start)
   );

   tdm_slot_mux #(.NUM_CH(1), .DATA_W(8), .SLOT_LEN(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .enable(en1), .mode_skip(1'b0),
      .in_data(dat1), .in_valid(vld1), .in_ready(ir1),
      .out_data(od1), .out_valid(ov1), .out_ready(ordy1),
      .slot_ch(ch1), .slot_start(ss1)
   );

   typedef struct {
      bit         rst;
      bit         en;
      bit         skip;
      logic [3:0] vld;
      bit         ordy;
      logic [7:0] d0v;
      logic [3:0] e_ir;
      bit         e_ov;
      logic [7:0] e_od;
      logic [1:0] e_ch;
      bit         e_ss;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic void add(bit rst, bit en, bit skip, logic [3:0] vld, bit ordy,
                               logic [7:0] d0v, logic [3:0] ir, bit ov, logic [7:0] od,
                               logic [1:0] ch, bit ss);
      vec_t v;
      v.rst = rst; v.en = en; v.skip = skip; v.vld = vld; v.ordy = ordy; v.d0v = d0v;
      v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_ch = ch; v.e_ss = ss;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable = 1'b0; mode_skip = 1'b0; in_valid = 4'h0; out_ready = 1'b0; d0 = 8'hA0;
      en1 = 1'b0; vld1 = 1'b0; ordy1 = 1'b0; dat1 = 8'h00;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [11:0] exp1 [4];

   initial begin
      //  rst en skp vld    rdy d0      ir    ov od     ch ss
      // Normal rotation, all valid, 4 words per slot, one GAP between slots.
      add(1, 1, 0, 4'hF, 1, 8'hA0, 4'h0, 0, 8'h00, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h1, 0, 8'h00, 0, 1);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h1, 1, 8'hA0, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h1, 1, 8'hA0, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h1, 1, 8'hA0, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h0, 1, 8'hA0, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h2, 0, 8'hA0, 1, 1);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h2, 1, 8'hB1, 1, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h2, 1, 8'hB1, 1, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h2, 1, 8'hB1, 1, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h0, 1, 8'hB1, 1, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h4, 0, 8'hB1, 2, 1);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h4, 1, 8'hC2, 2, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h4, 1, 8'hC2, 2, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h4, 1, 8'hC2, 2, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h0, 1, 8'hC2, 2, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h8, 0, 8'hC2, 3, 1);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h8, 1, 8'hD3, 3, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h8, 1, 8'hD3, 3, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h8, 1, 8'hD3, 3, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h0, 1, 8'hD3, 3, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h1, 0, 8'hD3, 0, 1);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h1, 1, 8'hA0, 0, 0);
      // Skip mode, only ch2 valid: ch2 owns every slot.
      add(1, 1, 1, 4'h4, 1, 8'hA0, 4'h0, 0, 8'h00, 0, 0);
      add(0, 1, 1, 4'h4, 1, 8'hA0, 4'h4, 0, 8'h00, 2, 1);
      add(0, 1, 1, 4'h4, 1, 8'hA0, 4'h4, 1, 8'hC2, 2, 0);
      add(0, 1, 1, 4'h4, 1, 8'hA0, 4'h4, 1, 8'hC2, 2, 0);
      add(0, 1, 1, 4'h4, 1, 8'hA0, 4'h4, 1, 8'hC2, 2, 0);
      add(0, 1, 1, 4'h4, 1, 8'hA0, 4'h0, 1, 8'hC2, 2, 0);
      add(0, 1, 1, 4'h4, 1, 8'hA0, 4'h4, 0, 8'hC2, 2, 1);
      add(0, 1, 1, 4'h4, 1, 8'hA0, 4'h4, 1, 8'hC2, 2, 0);
      // Skip mode, ch1 sends 2 words then drops: early GAP, then ch3.
      add(1, 1, 1, 4'hA, 1, 8'hA0, 4'h0, 0, 8'h00, 0, 0);
      add(0, 1, 1, 4'hA, 1, 8'hA0, 4'h2, 0, 8'h00, 1, 1);
      add(0, 1, 1, 4'hA, 1, 8'hA0, 4'h2, 1, 8'hB1, 1, 0);
      add(0, 1, 1, 4'h8, 1, 8'hA0, 4'h2, 1, 8'hB1, 1, 0);
      add(0, 1, 1, 4'h8, 1, 8'hA0, 4'h0, 0, 8'hB1, 1, 0);
      add(0, 1, 1, 4'h8, 1, 8'hA0, 4'h8, 0, 8'hB1, 3, 1);
      add(0, 1, 1, 4'h8, 1, 8'hA0, 4'h8, 1, 8'hD3, 3, 0);
      // Backpressure: ready low, data held while ch0 data changes, slot still ends.
      add(1, 1, 0, 4'hF, 1, 8'hA0, 4'h0, 0, 8'h00, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h1, 0, 8'h00, 0, 1);
      add(0, 1, 0, 4'hF, 0, 8'hA1, 4'h0, 1, 8'hA0, 0, 0);
      add(0, 1, 0, 4'hF, 0, 8'hA2, 4'h0, 1, 8'hA0, 0, 0);
      add(0, 1, 0, 4'hF, 0, 8'hA3, 4'h0, 1, 8'hA0, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA4, 4'h0, 1, 8'hA0, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA4, 4'h2, 0, 8'hA0, 1, 1);
      // Enable drop at cnt=2: ready falls at once, slot runs out, IDLE, resume at ch1.
      add(1, 1, 0, 4'hF, 1, 8'hA0, 4'h0, 0, 8'h00, 0, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h1, 0, 8'h00, 0, 1);
      add(0, 0, 0, 4'hF, 1, 8'hA0, 4'h0, 1, 8'hA0, 0, 0);
      add(0, 0, 0, 4'hF, 1, 8'hA0, 4'h0, 0, 8'hA0, 0, 0);
      add(0, 0, 0, 4'hF, 1, 8'hA0, 4'h0, 0, 8'hA0, 0, 0);
      add(0, 0, 0, 4'hF, 1, 8'hA0, 4'h0, 0, 8'hA0, 0, 0);
      add(0, 0, 0, 4'hF, 1, 8'hA0, 4'h0, 0, 8'hA0, 1, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h0, 0, 8'hA0, 1, 0);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h2, 0, 8'hA0, 1, 1);
      add(0, 1, 0, 4'hF, 1, 8'hA0, 4'h2, 1, 8'hB1, 1, 0);

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         enable    = tbl[i].en;
         mode_skip = tbl[i].skip;
         in_valid  = tbl[i].vld;
         out_ready = tbl[i].ordy;
         d0        = tbl[i].d0v;
         @(negedge clock);
         chk($sformatf("row%0d {ir,ov,od,ch,ss}", i),
             32'({in_ready, out_valid, out_data, slot_ch, slot_start}),
             32'({tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_ch, tbl[i].e_ss}));
         @(posedge clock);
         #1;
      end

      // Asynchronous reset mid-DWELL with a word pending.
      do_reset();
      enable = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
      @(negedge clock);
      @(posedge clock); #1;
      @(negedge clock);
      chk("rst_pre_ready", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      @(negedge clock);
      chk("rst_pre_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      chk("rst_rel_ch_ir", 32'({slot_ch, in_ready}), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("rst_restart", 32'({slot_ch, in_ready, slot_start}), 32'({2'd0, 4'h1, 1'b1}));

      // Single channel, single-cycle slot: DWELL and GAP alternate on ch0.
      do_reset();
      en1 = 1'b1; vld1 = 1'b1; ordy1 = 1'b1; dat1 = 8'h5A;
      exp1[0] = 12'h000;
      exp1[1] = 12'h801;
      exp1[2] = 12'h568;
      exp1[3] = 12'h969;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk($sformatf("n1_cycle%0d {ir,ov,od,ch,ss}", c),
             32'({ir1, ov1, od1, ch1, ss1}), 32'(exp1[c]));
         @(posedge clock); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
